// File: rtl/axi_node_pkg.sv
// Shared definitions for the AXI node read path.
//   route_idx_w : width of the routing index prepended to ARID
//   ARLEN_W, ARSIZE_W, ARBURST_W : fixed AXI AR control field widths
//   ar_ctrl_t   : width-independent part of the AR payload (len/size/burst)
package axi_node_pkg;

  localparam int ARLEN_W   = 8;
  localparam int ARSIZE_W  = 3;
  localparam int ARBURST_W = 2;

  // Number of index bits needed to name one of n_init initiators.
  // Clamped to 1 so a degenerate configuration still yields a legal vector.
  function automatic int route_idx_w(input int n_init);
    return (n_init < 2) ? 1 : $clog2(n_init);
  endfunction

  typedef struct packed {
    logic [ARLEN_W-1:0]   len;
    logic [ARSIZE_W-1:0]  size;
    logic [ARBURST_W-1:0] burst;
  } ar_ctrl_t;

endpackage

// File: rtl/axi_rr_arb_tree_ptr.sv
// Combinational round-robin picker.
//   req_i         : request vector, one bit per requester
//   ptr_i         : index with highest priority this cycle (< N_REQ)
//   grant_idx_o   : first set request at or above ptr_i, wrapping to 0
//   grant_valid_o : any request present
module axi_rr_arb_tree_ptr #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_valid_o
);

  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_vld;
  logic             lo_vld;

  // Requests at or above ptr win over wrapped ones below ptr. Scanning
  // downward lets the lowest index in each half overwrite the others, so
  // no "found" flag is needed. The wrap is a plain compare, which keeps
  // non-power-of-two requester counts correct.
  always_comb begin
    hi_idx = '0;
    hi_vld = 1'b0;
    lo_idx = '0;
    lo_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        if (IDX_W'(i) >= ptr_i) begin
          hi_idx = IDX_W'(i);
          hi_vld = 1'b1;
        end else begin
          lo_idx = IDX_W'(i);
          lo_vld = 1'b1;
        end
      end
    end
    grant_valid_o = hi_vld | lo_vld;
    grant_idx_o   = hi_vld ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/axi_request_arbiter_ar.sv
// AR-channel round-robin arbiter: N_INIT_PORT initiators onto one target.
// The winner's index is prepended to its ARID so R beats can be routed back,
// and the target side is driven from a one-entry register slice.
//   clk, rst            : clock, synchronous active-high reset
//   arvalid_i/arready_o : per-initiator AR handshake
//   ar*_i               : packed per-initiator payload, slice i = port i
//   arvalid_o/arready_i : target AR handshake
//   ar*_o               : registered payload, arid_o = {grant index, arid}
// Handshake: a transfer happens on a port in every cycle where its valid and
// ready are both high; valid must not depend on ready, and once arvalid_o is
// raised the payload holds until arready_i is seen high.
module axi_request_arbiter_ar
  import axi_node_pkg::*;
#(
  parameter int N_INIT_PORT = 4,
  parameter int AXI_ID_IN   = 16,
  parameter int AXI_ID_OUT  = AXI_ID_IN + $clog2(N_INIT_PORT),
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_USER_W  = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_INIT_PORT-1:0]            arvalid_i,
  output logic [N_INIT_PORT-1:0]            arready_o,
  input  logic [N_INIT_PORT*AXI_ID_IN-1:0]  arid_i,
  input  logic [N_INIT_PORT*AXI_ADDR_W-1:0] araddr_i,
  input  logic [N_INIT_PORT*ARLEN_W-1:0]    arlen_i,
  input  logic [N_INIT_PORT*ARSIZE_W-1:0]   arsize_i,
  input  logic [N_INIT_PORT*ARBURST_W-1:0]  arburst_i,
  input  logic [N_INIT_PORT*AXI_USER_W-1:0] aruser_i,
  output logic                              arvalid_o,
  input  logic                              arready_i,
  output logic [AXI_ID_OUT-1:0]             arid_o,
  output logic [AXI_ADDR_W-1:0]             araddr_o,
  output logic [ARLEN_W-1:0]                arlen_o,
  output logic [ARSIZE_W-1:0]               arsize_o,
  output logic [ARBURST_W-1:0]              arburst_o,
  output logic [AXI_USER_W-1:0]             aruser_o
);

  localparam int IDX_W = route_idx_w(N_INIT_PORT);

  // Full AR payload carried as one vector; widths follow the parameters,
  // so the struct lives here rather than in the shared package.
  typedef struct packed {
    logic [AXI_ID_OUT-1:0] id;
    logic [AXI_ADDR_W-1:0] addr;
    ar_ctrl_t              ctrl;
    logic [AXI_USER_W-1:0] user;
  } ar_payload_t;

  ar_payload_t      payload_q, payload_d, cand;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             can_load;
  logic             load;

  axi_rr_arb_tree_ptr #(
    .N_REQ (N_INIT_PORT),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i         (arvalid_i),
    .ptr_i         (ptr_q),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  // The slice accepts when empty or when its current entry leaves this cycle.
  // Reset blocks acceptance so nothing is consumed in the reset cycle.
  assign can_load = ~valid_q | arready_i;
  assign load     = can_load & grant_valid & ~rst;

  // Select the granted port's payload and extend its ID with the index.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N_INIT_PORT; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        cand.id         = AXI_ID_OUT'({grant_idx, arid_i[i*AXI_ID_IN +: AXI_ID_IN]});
        cand.addr       = araddr_i[i*AXI_ADDR_W +: AXI_ADDR_W];
        cand.ctrl.len   = arlen_i[i*ARLEN_W +: ARLEN_W];
        cand.ctrl.size  = arsize_i[i*ARSIZE_W +: ARSIZE_W];
        cand.ctrl.burst = arburst_i[i*ARBURST_W +: ARBURST_W];
        cand.user       = aruser_i[i*AXI_USER_W +: AXI_USER_W];
      end
    end
  end

  always_comb begin
    arready_o = '0;
    for (int i = 0; i < N_INIT_PORT; i++) begin
      arready_o[i] = load & (grant_idx == IDX_W'(i));
    end
  end

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    ptr_d     = ptr_q;
    if (load) begin
      // Load wins over drain, so a drain+load cycle keeps valid high.
      valid_d   = 1'b1;
      payload_d = cand;
      ptr_d     = (grant_idx == IDX_W'(N_INIT_PORT - 1)) ? '0 : grant_idx + IDX_W'(1);
    end else if (valid_q & arready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      ptr_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      ptr_q     <= ptr_d;
    end
  end

  assign arvalid_o = valid_q;
  assign arid_o    = payload_q.id;
  assign araddr_o  = payload_q.addr;
  assign arlen_o   = payload_q.ctrl.len;
  assign arsize_o  = payload_q.ctrl.size;
  assign arburst_o = payload_q.ctrl.burst;
  assign aruser_o  = payload_q.user;

endmodule
